uart_cmd_rx: RTL

UART receiver and command decoder for the host-to-scope direction: the counterpart of the UART transmitter that streams downsampled ADC bytes to the host. Deserialises 8N1 frames on the RX pin and parses two-byte commands (opcode, argument) into control registers for the capture path: decimation factor and run enable. Sits in `top` between `UART_RX` and the downsampling/output stage.

---
 rtl/uart_cmd_rx.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_rx.sv
// UART 8N1 receiver feeding a two-byte command parser ('D' decimation, 'R' run enable).
// All state is synchronously reset; iRx is treated as asynchronous and synchronised first.
module uart_cmd_rx #(
    parameter int pClksPerBit = 868,
    parameter int pCmdTimeout = 1000000
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iRx,
    output logic [7:0] oRxByte,
    output logic       oRxValid,
    output logic       oFrameErr,
    output logic [7:0] oDecim,
    output logic       oRunEn,
    output logic       oCmdValid,
    output logic       oCmdErr
);

    localparam int TW = (pClksPerBit > 1) ? $clog2(pClksPerBit) : 1;
    localparam int CW = $clog2(pCmdTimeout + 1);
    localparam logic [TW-1:0] HALF_BIT = TW'((pClksPerBit - 1) / 2);
    localparam logic [TW-1:0] LAST_BIT = TW'(pClksPerBit - 1);
    localparam logic [CW-1:0] CMD_LIMIT = CW'(pCmdTimeout);
    localparam logic [7:0] OP_DECIM = 8'h44;
    localparam logic [7:0] OP_RUN = 8'h52;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_e;

    typedef enum logic {
        P_OP,
        P_ARG
    } p_state_e;

    logic [1:0]    sync_q, sync_d;
    rx_state_e     rx_state_q, rx_state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          rx_valid_q, rx_valid_d;
    logic          frame_err_q, frame_err_d;

    p_state_e      p_state_q, p_state_d;
    logic          op_run_q, op_run_d;
    logic [CW-1:0] tmo_q, tmo_d;
    logic [7:0]    decim_q, decim_d;
    logic          run_en_q, run_en_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic          cmd_err_q, cmd_err_d;

    logic rx_sync;
    logic rx_tick;
    logic tmo_expired;
    logic is_opcode;

    assign rx_sync = sync_q[1];
    // The start bit is sampled at mid-bit; every later sample is a full bit period on.
    assign rx_tick = (rx_state_q == RX_START) ? (timer_q == HALF_BIT) : (timer_q == LAST_BIT);
    assign tmo_expired = (tmo_q == CMD_LIMIT - CW'(1));
    assign is_opcode = (rx_byte_q == OP_DECIM) || (rx_byte_q == OP_RUN);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            sync_q      <= 2'b11;
            rx_state_q  <= RX_IDLE;
            timer_q     <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            p_state_q   <= P_OP;
            op_run_q    <= 1'b0;
            tmo_q       <= '0;
            decim_q     <= 8'h01;
            run_en_q    <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            rx_state_q  <= rx_state_d;
            timer_q     <= timer_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            p_state_q   <= p_state_d;
            op_run_q    <= op_run_d;
            tmo_q       <= tmo_d;
            decim_q     <= decim_d;
            run_en_q    <= run_en_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            RX_IDLE:  if (!rx_sync) rx_state_d = RX_START;
            RX_START: if (rx_tick) rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
            RX_STOP:  if (rx_tick) rx_state_d = rx_sync ? RX_IDLE : RX_BREAK;
            RX_BREAK: if (rx_sync) rx_state_d = RX_IDLE;
            default:  rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        sync_d      = {sync_q[0], iRx};
        timer_d     = rx_tick ? '0 : timer_q + TW'(1);
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        case (rx_state_q)
            RX_START: if (rx_tick) bit_cnt_d = '0;
            RX_DATA: begin
                if (rx_tick) begin
                    shift_d   = {rx_sync, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            RX_STOP: begin
                if (rx_tick) begin
                    if (rx_sync) begin
                        rx_byte_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: timer_d = '0;
        endcase
    end

    always_comb begin
        p_state_d = p_state_q;
        case (p_state_q)
            P_OP:    if (rx_valid_q && is_opcode) p_state_d = P_ARG;
            P_ARG:   if (rx_valid_q || frame_err_q || tmo_expired) p_state_d = P_OP;
            default: p_state_d = P_OP;
        endcase
    end

    // A byte arriving in the same cycle as timeout expiry takes priority over the abort.
    always_comb begin
        op_run_d    = op_run_q;
        tmo_d       = (tmo_q == CMD_LIMIT) ? tmo_q : tmo_q + CW'(1);
        decim_d     = decim_q;
        run_en_d    = run_en_q;
        cmd_valid_d = 1'b0;
        cmd_err_d   = 1'b0;
        case (p_state_q)
            P_OP: begin
                if (rx_valid_q) begin
                    if (is_opcode) begin
                        op_run_d = (rx_byte_q == OP_RUN);
                        tmo_d    = '0;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            P_ARG: begin
                if (rx_valid_q) begin
                    if (op_run_q) begin
                        run_en_d    = rx_byte_q[0];
                        cmd_valid_d = 1'b1;
                    end else if (rx_byte_q == 8'h00) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        decim_d     = rx_byte_q;
                        cmd_valid_d = 1'b1;
                    end
                end else if (frame_err_q || tmo_expired) begin
                    cmd_err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign oRxByte   = rx_byte_q;
    assign oRxValid  = rx_valid_q;
    assign oFrameErr = frame_err_q;
    assign oDecim    = decim_q;
    assign oRunEn    = run_en_q;
    assign oCmdValid = cmd_valid_q;
    assign oCmdErr   = cmd_err_q;

endmodule
